// File: rtl/mem_arbiter16_if.sv
// Bus bundle between the fetch/data requesters, the shared memory and the arbiter.
// The arbiter uses the slave modport; the requester/memory side uses master.
interface mem_arbiter16_if #(
    parameter int AW = 10,
    parameter int DW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_stall;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_stall, if_rvalid, if_rdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_stall, if_rvalid, if_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter16.sv
// Single-port memory arbiter between instruction fetch (IF) and data memory (DM).
// DM wins by default; IF is forced through after STARVE_MAX consecutive denials.
module mem_arbiter16 #(
    parameter int AW         = 10,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 3
) (
    input logic            clk,
    input logic            rst_n,
    mem_arbiter16_if.slave bus
);
    localparam int SW = ($clog2(STARVE_MAX + 1) < 2) ? 2 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    owner_t        owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] if_rdata_q, dm_rdata_q;
    logic          if_force;
    logic          if_gnt;
    logic          dm_gnt;
    logic          we_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= OWN_NONE;
            starve_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            if (owner_q == OWN_IF)
                if_rdata_q <= bus.mem_rdata;
            if (owner_q == OWN_DM)
                dm_rdata_q <= bus.mem_rdata;
        end
    end

    // Grants are gated by rst_n so every strobe is low for the whole reset window.
    always_comb begin
        if_force = 1'b0;
        if_gnt   = 1'b0;
        dm_gnt   = 1'b0;
        we_d     = 1'b0;
        owner_d  = OWN_NONE;
        starve_d = '0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        if (rst_n) begin
            if_force = bus.if_req && (starve_q == STARVE_LIM);
            dm_gnt   = bus.dm_req && !if_force;
            if_gnt   = bus.if_req && !dm_gnt;
            if (dm_gnt) begin
                addr_d  = bus.dm_addr;
                wdata_d = bus.dm_wdata;
                we_d    = bus.dm_we;
                owner_d = bus.dm_we ? OWN_NONE : OWN_DM;
            end else if (if_gnt) begin
                addr_d  = bus.if_addr;
                owner_d = OWN_IF;
            end
            if (bus.if_req && !if_gnt)
                starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + SW'(1);
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.dm_gnt    = dm_gnt;
    assign bus.if_stall  = bus.if_req & ~if_gnt;
    assign bus.mem_en    = if_gnt | dm_gnt;
    assign bus.mem_we    = we_d;
    assign bus.mem_addr  = addr_d;
    assign bus.mem_wdata = wdata_d;

    // Read data arrives from memory in the rvalid cycle itself; the registers only hold it afterwards.
    assign bus.if_rvalid = (owner_q == OWN_IF);
    assign bus.dm_rvalid = (owner_q == OWN_DM);
    assign bus.if_rdata  = (owner_q == OWN_IF) ? bus.mem_rdata : if_rdata_q;
    assign bus.dm_rdata  = (owner_q == OWN_DM) ? bus.mem_rdata : dm_rdata_q;
endmodule

// File: doc/mem_arbiter16.md
MEM_ARBITER16 -- requirements
Module: mem_arbiter16

Interface
REQ-001 The module SHALL expose parameters (name, default, meaning):
- AW, 10, word-address width.
- DW, 16, data width.
- STARVE_MAX, 3, consecutive IF denials before IF is forced to win.
REQ-002 The module SHALL expose ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_req  in  1  instruction-fetch read request.
- if_addr  in  AW  fetch word address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_stall  out  1  if_req & ~if_gnt.
- if_rvalid  out  1  if_rdata valid.
- if_rdata  out  DW  fetched instruction word.
- dm_req  in  1  data-memory request from the MEM stage.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  AW  data word address.
- dm_wdata  in  DW  store data.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  dm_rdata valid (loads only).
- dm_rdata  out  DW  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid exactly 1 cycle after a mem_en & ~mem_we access.

Function
REQ-003 The block SHALL share one single-port memory between fetch (IF) and data (DM) requesters, granting at most one access per cycle.
REQ-004 Grants SHALL be combinational from the current requests and registered state; mem_en/mem_we/mem_addr/mem_wdata SHALL drive the granted request in the same cycle.
REQ-005 Default priority: DM over IF.
REQ-006 A 2-bit-minimum starve counter SHALL increment on each cycle with if_req & ~if_gnt, clear on if_gnt or ~if_req, and saturate at STARVE_MAX.
REQ-007 When the starve counter equals STARVE_MAX and if_req = 1, IF SHALL win that cycle over DM; dm_gnt = 0.
REQ-008 With no request: mem_en = 0, mem_we = 0, mem_addr and mem_wdata hold their previous values, and both gnt signals = 0.
REQ-009 A granted read SHALL record its owner in a 1-cycle pipeline register; next cycle, the owner's rvalid = 1 and its rdata = mem_rdata.
REQ-010 if_rdata and dm_rdata SHALL be registered and hold their last valid value until the next rvalid for that port.
REQ-011 A granted store SHALL assert mem_we = 1 and produce no rvalid.
REQ-012 if_rvalid and dm_rvalid SHALL never both be 1 in the same cycle.
REQ-013 Back-to-back grants SHALL sustain one access per cycle with no bubble. A read granted in cycle N and another in N+1 return data in N+1 and N+2.
REQ-014 A requester whose req drops without a grant SHALL be treated as withdrawn; no state retains it except the starve counter, which clears.
REQ-015 Addresses are word addresses; AW-bit wrap-around is the memory's behaviour, and the block SHALL not modify addresses.

Reset
REQ-016 While rst_n = 0, regardless of clk, all of the following SHALL be 0:
- if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we.
- if_rdata, dm_rdata, mem_addr, mem_wdata.
- The starve counter and the owner pipeline register.
REQ-017 A read in flight when reset asserts SHALL be discarded; no rvalid appears after reset releases.
REQ-018 The first grant SHALL occur on the first rising clk edge after rst_n deasserts.

Verification
REQ-019 Bench scenarios:
- IF only: if_req = 1, if_addr = 0x005, mem_rdata = 0x1234 next cycle -> if_gnt = 1 and mem_addr = 0x005 in cycle N; if_rvalid = 1 and if_rdata = 0x1234 in N+1.
- Conflict: dm_req (load, 0x020) and if_req (0x006) together -> dm_gnt = 1, if_stall = 1; dm_rvalid next cycle, if_rvalid = 0.
- Starvation with STARVE_MAX = 3: both requesting continuously -> DM granted 3 cycles, IF granted on the 4th, then DM again; the pattern repeats.
- Store: dm_req = 1, dm_we = 1, dm_addr = 0x3FF, dm_wdata = 0xBEEF -> mem_we = 1, mem_wdata = 0xBEEF, no dm_rvalid.
- Reset mid-read: IF read granted, rst_n = 0 before next edge -> if_rvalid stays 0 and all outputs read 0 immediately.
- Idle: no requests for 5 cycles -> mem_en = 0, rdata outputs hold prior values, starve counter = 0.
